// File: rtl/dmem_responder_if.sv
// Data-port bus between the core (master) and dmem_responder (slave).
interface dmem_responder_if;
    logic        bus_lock;
    logic        memory_mode;
    logic [29:0] data_address;
    logic [3:0]  data_mask;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        bus_error;

    modport master (
        output bus_lock, memory_mode, data_address, data_mask, data_out,
        input  data_in, bus_error
    );

    modport slave (
        input  bus_lock, memory_mode, data_address, data_mask, data_out,
        output data_in, bus_error
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-maskable word RAM with one-enabled-cycle read latency.
// Optional 64-bit machine timer (mtime/mtimecmp/timer_irq) built when DMEM_TIMER_EN is defined.
module dmem_responder #(
    parameter int unsigned DEPTH      = 4096,
    parameter logic [29:0] TIMER_BASE = 30'h3FFF_FFF0,
    parameter int unsigned TIMER_DIV  = 1
) (
    input  logic            clk,
    input  logic            async_rst,
    input  logic            clk_en,
    dmem_responder_if.slave bus,
    output logic            timer_irq
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] ram_idx;
    logic          access, is_wr, in_ram, in_tmr, unmapped;
    logic [31:0]   ram_rd, tmr_rd;
    logic [31:0]   data_in_q, data_in_d;
    logic          bus_error_q, bus_error_d;
    logic          timer_irq_q, timer_irq_d;

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  mask);
        logic [31:0] r;
        r = old_w;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    assign access   = clk_en & bus.bus_lock;
    assign is_wr    = bus.memory_mode;
    assign in_ram   = {2'b00, bus.data_address} < 32'(DEPTH);
    assign ram_idx  = bus.data_address[AW-1:0];
    assign unmapped = !in_ram && !in_tmr;
    assign ram_rd   = mem[ram_idx];

    // RAM is deliberately unreset; store-then-load needs no forwarding since edges commit in order.
    always_ff @(posedge clk) begin
        if (access && is_wr && in_ram) begin
            mem[ram_idx] <= merge(mem[ram_idx], bus.data_out, bus.data_mask);
        end
    end

`ifdef DMEM_TIMER_EN
    localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic          tick, tmr_wr;

    assign in_tmr = bus.data_address[29:2] == TIMER_BASE[29:2];
    assign tick   = presc_q == PW'(TIMER_DIV - 1);
    assign tmr_wr = access & is_wr & in_tmr;

    // Written mtime lanes overlay the already-incremented value, so the increment is never lost.
    always_comb begin
        presc_d    = tick ? '0 : presc_q + PW'(1);
        mtime_d    = mtime_q + 64'(tick);
        mtimecmp_d = mtimecmp_q;
        if (tmr_wr) begin
            unique case (bus.data_address[1:0])
                2'd0: mtime_d[31:0]     = merge(mtime_d[31:0],     bus.data_out, bus.data_mask);
                2'd1: mtime_d[63:32]    = merge(mtime_d[63:32],    bus.data_out, bus.data_mask);
                2'd2: mtimecmp_d[31:0]  = merge(mtimecmp_d[31:0],  bus.data_out, bus.data_mask);
                2'd3: mtimecmp_d[63:32] = merge(mtimecmp_d[63:32], bus.data_out, bus.data_mask);
            endcase
        end
        timer_irq_d = mtime_d >= mtimecmp_d;
    end

    always_comb begin
        unique case (bus.data_address[1:0])
            2'd0: tmr_rd = mtime_q[31:0];
            2'd1: tmr_rd = mtime_q[63:32];
            2'd2: tmr_rd = mtimecmp_q[31:0];
            2'd3: tmr_rd = mtimecmp_q[63:32];
        endcase
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else if (clk_en) begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end
`else
    logic unused_timer_cfg;
    assign unused_timer_cfg = (TIMER_DIV == 0) | (TIMER_BASE == '0);
    assign in_tmr      = 1'b0;
    assign tmr_rd      = '0;
    assign timer_irq_d = 1'b0;
`endif

    always_comb begin
        data_in_d   = data_in_q;
        bus_error_d = access & unmapped;
        if (access && !is_wr) begin
            data_in_d = in_ram ? ram_rd : (in_tmr ? tmr_rd : '0);
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            data_in_q   <= '0;
            bus_error_q <= 1'b0;
            timer_irq_q <= 1'b0;
        end else if (clk_en) begin
            data_in_q   <= data_in_d;
            bus_error_q <= bus_error_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    assign bus.data_in   = data_in_q;
    assign bus.bus_error = bus_error_q;
    assign timer_irq     = timer_irq_q;
endmodule
